// File: rtl/led_pkg.sv
// Shared definitions for the LED fade driver: FSM state encodings and default sizing.
package led_pkg;

  localparam int unsigned PWM_BITS_DEF = 8;
  localparam int unsigned STEP_DIV_DEF = 50000;

  typedef enum logic [1:0] {
    OFF       = 2'd0,
    RAMP_UP   = 2'd1,
    ON        = 2'd2,
    RAMP_DOWN = 2'd3
  } fade_state_t;

endpackage

// File: rtl/led_pwm_gen.sv
// Free-running PWM counter with registered compare; ON/OFF states force the pin level.
module led_pwm_gen
  import led_pkg::*;
#(
  parameter int unsigned PWM_BITS = PWM_BITS_DEF
) (
  input  logic                clk,
  input  logic                rst,
  input  fade_state_t         state,
  input  logic [PWM_BITS-1:0] duty_eff,
  output logic                led_out
);

  logic [PWM_BITS-1:0] pwm_cnt;

  // Counter wraps MAX->0 naturally; the FSM never touches it.
  always_ff @(posedge clk) begin
    if (rst) begin
      pwm_cnt <= '0;
      led_out <= 1'b0;
    end else begin
      pwm_cnt <= pwm_cnt + PWM_BITS'(1);
      case (state)
        ON:      led_out <= 1'b1;
        OFF:     led_out <= 1'b0;
        default: led_out <= (pwm_cnt < duty_eff);
      endcase
    end
  end

endmodule

// File: rtl/led_fade_driver.sv
// LED fade driver: ramps brightness up/down following led_in, drives a PWM pin.
// Optional gamma correction of the PWM duty when LED_FADE_GAMMA_EN is defined.
module led_fade_driver
  import led_pkg::*;
#(
  parameter int unsigned PWM_BITS = PWM_BITS_DEF,
  parameter int unsigned STEP_DIV = STEP_DIV_DEF
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                led_in,
  output logic                led_out,
  output logic [PWM_BITS-1:0] duty,
  output logic                busy
);

  localparam int unsigned PRE_W = (STEP_DIV > 1) ? $clog2(STEP_DIV) : 1;
  localparam logic [PWM_BITS-1:0] MAX = '1;
  localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(STEP_DIV - 1);

  fade_state_t         state;
  logic [PWM_BITS-1:0] level;
  logic [PRE_W-1:0]    presc;
  logic [PWM_BITS-1:0] duty_eff;
  logic                step_c;

  assign step_c = (presc == PRE_LAST);

  // Reversal takes priority over a step; levels saturate so they never wrap.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= OFF;
      level <= '0;
      presc <= '0;
      busy  <= 1'b0;
    end else begin
      case (state)
        OFF: begin
          level <= '0;
          presc <= '0;
          if (led_in) begin
            state <= RAMP_UP;
            busy  <= 1'b1;
          end
        end
        RAMP_UP: begin
          if (!led_in) begin
            state <= RAMP_DOWN;
            presc <= '0;
          end else if (step_c) begin
            presc <= '0;
            if (level >= MAX - PWM_BITS'(1)) begin
              level <= MAX;
              state <= ON;
              busy  <= 1'b0;
            end else begin
              level <= level + PWM_BITS'(1);
            end
          end else begin
            presc <= presc + PRE_W'(1);
          end
        end
        ON: begin
          level <= MAX;
          presc <= '0;
          if (!led_in) begin
            state <= RAMP_DOWN;
            busy  <= 1'b1;
          end
        end
        default: begin
          if (led_in) begin
            state <= RAMP_UP;
            presc <= '0;
          end else if (step_c) begin
            presc <= '0;
            if (level <= PWM_BITS'(1)) begin
              level <= '0;
              state <= OFF;
              busy  <= 1'b0;
            end else begin
              level <= level - PWM_BITS'(1);
            end
          end else begin
            presc <= presc + PRE_W'(1);
          end
        end
      endcase
    end
  end

  assign duty = level;

`ifdef LED_FADE_GAMMA_EN
  localparam int unsigned SQ_W = 2 * PWM_BITS;
  logic [SQ_W-1:0] level_sq;

  // Full-width square so the shift sees every product bit.
  assign level_sq = SQ_W'(level) * SQ_W'(level);
  assign duty_eff = PWM_BITS'(level_sq >> PWM_BITS);
`else
  assign duty_eff = level;
`endif

  led_pwm_gen #(
    .PWM_BITS (PWM_BITS)
  ) u_pwm (
    .clk      (clk),
    .rst      (rst),
    .state    (state),
    .duty_eff (duty_eff),
    .led_out  (led_out)
  );

endmodule

// File: tb/tb_led_fade_driver.sv
// Bench for led_fade_driver: scoreboard against a cycle model, directed spot checks,
// and PWM duty-window measurement on a slow-stepping instance.
module tb_led_fade_driver;

  localparam int PB       = 4;
  localparam int DIV      = 2;
  localparam int MAXL     = 15;
  localparam int SLOW_DIV = 1000;

  typedef struct {
    int duty;
    int busy;
    int led;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       led_in = 1'b0;
  logic       led_out;
  logic [3:0] duty;
  logic       busy;

  logic       rst_s = 1'b1;
  logic       led_in_s = 1'b0;
  logic       led_out_s;
  logic [3:0] duty_s;
  logic       busy_s;

  int n_cmp = 0;
  int n_bad = 0;
  exp_t q[$];

  // Reference model: mode 0 dark, 1 brightening, 2 lit, 3 dimming.
  int m_mode = 0;
  int m_lvl  = 0;
  int m_tick = 0;
  int m_pwm  = 0;
  int m_led  = 0;

  always #5 clk = ~clk;

  led_fade_driver #(.PWM_BITS(PB), .STEP_DIV(DIV)) dut (
    .clk(clk), .rst(rst), .led_in(led_in),
    .led_out(led_out), .duty(duty), .busy(busy)
  );

  led_fade_driver #(.PWM_BITS(PB), .STEP_DIV(SLOW_DIV)) dut_slow (
    .clk(clk), .rst(rst_s), .led_in(led_in_s),
    .led_out(led_out_s), .duty(duty_s), .busy(busy_s)
  );

  function automatic int eff(input int lvl);
`ifdef LED_FADE_GAMMA_EN
    return (lvl * lvl) / (1 << PB);
`else
    return lvl;
`endif
  endfunction

  task automatic cmp(input string nm, input int got, input int want);
    n_cmp++;
    if (got != want) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, got, want, $time);
    end
  endtask

  // Advance the model by one clock edge given the inputs sampled at that edge.
  task automatic model_edge(input bit r, input bit li);
    exp_t e;
    if (r) begin
      m_mode = 0; m_lvl = 0; m_tick = 0; m_pwm = 0; m_led = 0;
    end else begin
      m_led = (m_mode == 2) ? 1 : (m_mode == 0) ? 0 : ((m_pwm < eff(m_lvl)) ? 1 : 0);
      m_pwm = (m_pwm + 1) % (MAXL + 1);
      case (m_mode)
        0: if (li) begin m_mode = 1; m_tick = 0; end
        1: begin
          if (!li) begin
            m_mode = 3; m_tick = 0;
          end else if (m_tick == DIV - 1) begin
            m_tick = 0;
            m_lvl = (m_lvl + 1 > MAXL) ? MAXL : m_lvl + 1;
            if (m_lvl == MAXL) m_mode = 2;
          end else m_tick++;
        end
        2: if (!li) begin m_mode = 3; m_tick = 0; end
        default: begin
          if (li) begin
            m_mode = 1; m_tick = 0;
          end else if (m_tick == DIV - 1) begin
            m_tick = 0;
            m_lvl = (m_lvl - 1 < 0) ? 0 : m_lvl - 1;
            if (m_lvl == 0) m_mode = 0;
          end else m_tick++;
        end
      endcase
    end
    e.duty = m_lvl;
    e.busy = (m_mode == 1 || m_mode == 3) ? 1 : 0;
    e.led  = m_led;
    q.push_back(e);
  endtask

  task automatic drive(input bit r, input bit li);
    @(negedge clk);
    rst = r;
    led_in = li;
    model_edge(r, li);
  endtask

  task automatic settle();
    @(posedge clk);
    #2;
  endtask

  // Monitor: every edge produces one output sample to score.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (q.size() > 0) begin
        e = q.pop_front();
        cmp("sb_duty", int'(duty), e.duty);
        cmp("sb_busy", int'(busy), e.busy);
        cmp("sb_led_out", int'(led_out), e.led);
      end
    end
  end

  task automatic main_seq();
    int guard;
    // Reset held with led_in high.
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 1'b1);
      settle();
      cmp("rst_duty", int'(duty), 0);
      cmp("rst_busy", int'(busy), 0);
      cmp("rst_led_out", int'(led_out), 0);
    end
    drive(1'b0, 1'b1);
    settle();
    cmp("rel_busy", int'(busy), 1);
    cmp("rel_duty", int'(duty), 0);
    // Full ramp up: 15 steps of 2 cycles.
    for (int i = 0; i < 29; i++) drive(1'b0, 1'b1);
    settle();
    cmp("up29_duty", int'(duty), 14);
    cmp("up29_busy", int'(busy), 1);
    drive(1'b0, 1'b1);
    settle();
    cmp("up30_duty", int'(duty), 15);
    cmp("up30_busy", int'(busy), 0);
    for (int i = 0; i < 4; i++) begin
      drive(1'b0, 1'b1);
      settle();
      cmp("on_led_out", int'(led_out), 1);
    end
    // Full ramp down back to dark.
    for (int i = 0; i < 31; i++) drive(1'b0, 1'b0);
    settle();
    cmp("down_duty", int'(duty), 0);
    cmp("down_busy", int'(busy), 0);
    // Reversal at level 6.
    guard = 0;
    while (m_lvl != 6 && guard < 100) begin drive(1'b0, 1'b1); guard++; end
    cmp("reach6_guard", (guard < 100) ? 1 : 0, 1);
    drive(1'b0, 1'b0);
    settle();
    cmp("rev_duty", int'(duty), 6);
    cmp("rev_busy", int'(busy), 1);
    drive(1'b0, 1'b0);
    drive(1'b0, 1'b0);
    settle();
    cmp("rev2_duty", int'(duty), 5);
    for (int i = 0; i < 10; i++) drive(1'b0, 1'b0);
    settle();
    cmp("rev12_duty", int'(duty), 0);
    cmp("rev12_busy", int'(busy), 0);
    drive(1'b0, 1'b0);
    settle();
    cmp("rev13_led_out", int'(led_out), 0);
    // Reset mid-ramp at level 9.
    guard = 0;
    while (m_lvl != 9 && guard < 100) begin drive(1'b0, 1'b1); guard++; end
    cmp("reach9_guard", (guard < 100) ? 1 : 0, 1);
    drive(1'b1, 1'b1);
    settle();
    cmp("midrst_duty", int'(duty), 0);
    cmp("midrst_busy", int'(busy), 0);
    cmp("midrst_led_out", int'(led_out), 0);
    for (int i = 0; i < 3; i++) drive(1'b0, 1'b1);
    settle();
    cmp("rerise_duty", int'(duty), 1);
    // Randomized segments, occasional reset.
    for (int s = 0; s < 150; s++) begin
      bit li;
      int len;
      li  = 1'($urandom_range(0, 1));
      len = $urandom_range(1, 40);
      if ($urandom_range(0, 29) == 0) drive(1'b1, li);
      for (int i = 0; i < len; i++) drive(1'b0, li);
    end
  endtask

  // Slow instance: measure high time over 16-cycle windows at fixed levels.
  task automatic slow_seq();
    int hi;
    repeat (3) @(negedge clk);
    rst_s = 1'b0;
    led_in_s = 1'b1;
    repeat (3 * SLOW_DIV + 2) @(posedge clk);
    hi = 0;
    for (int i = 0; i < 16; i++) begin
      #1;
      hi += int'(led_out_s);
      if (i == 0) begin
        cmp("slow3_duty", int'(duty_s), 3);
        cmp("slow3_busy", int'(busy_s), 1);
      end
      @(posedge clk);
    end
    cmp("slow3_high_of_16", hi, eff(3));
    repeat (5 * SLOW_DIV - 16) @(posedge clk);
    hi = 0;
    for (int i = 0; i < 16; i++) begin
      #1;
      hi += int'(led_out_s);
      if (i == 0) cmp("slow8_duty", int'(duty_s), 8);
      @(posedge clk);
    end
    cmp("slow8_high_of_16", hi, eff(8));
  endtask

  initial begin
    fork
      main_seq();
      slow_seq();
    join
    @(posedge clk);
    #3;
    cmp("sb_drained", q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/led_fade_driver.md
LED_FADE_DRIVER -- requirements
Module: led_fade_driver

Interface
REQ-001 SHALL have parameter PWM_BITS, default 8, giving the brightness level width; MAX = 2^PWM_BITS-1.
REQ-002 SHALL have parameter STEP_DIV, default 50000, giving the number of clk cycles per one-level brightness step.
REQ-003 SHALL use one clock and a synchronous, active-high reset.
REQ-004 clk  input  1  single clock; all state updates on its rising edge.
REQ-005 rst  input  1  synchronous, active-high reset.
REQ-006 led_in  input  1  on/off blink level from the upstream blinker, same clock domain.
REQ-007 led_out  output  1  registered PWM drive to the LED pin.
REQ-008 duty  output  PWM_BITS  current linear brightness level.
REQ-009 busy  output  1  high while a ramp is in progress.

Function
REQ-010 FSM states SHALL be OFF, RAMP_UP, ON and RAMP_DOWN.
REQ-011 OFF: level=0; if led_in=1, go to RAMP_UP on the next edge.
REQ-012 RAMP_UP: level+1 per step; go to ON on the edge where level becomes MAX; if led_in=0, go to RAMP_DOWN on the next edge, keeping the current level.
REQ-013 ON: level=MAX; if led_in=0, go to RAMP_DOWN on the next edge.
REQ-014 RAMP_DOWN: level-1 per step; go to OFF on the edge where level becomes 0; if led_in=1, go to RAMP_UP on the next edge, keeping the current level.
REQ-015 Level SHALL never jump on a direction reversal, and SHALL never wrap past 0 or MAX.
REQ-016 Step prescaler: counts 0..STEP_DIV-1 only in ramp states; clears to 0 on every state change.
REQ-017 Step rule: a step SHALL occur on the edge where the prescaler equals STEP_DIV-1, then the prescaler wraps to 0.
REQ-018 PWM counter: free-running, 0..MAX, wraps MAX->0, unaffected by the FSM.
REQ-019 led_out SHALL be registered (pwm_cnt < duty_eff).
REQ-020 Overrides: led_out SHALL be forced 1 in ON and forced 0 in OFF.
REQ-021 duty SHALL equal level (linear, pre-correction); busy SHALL be 1 in RAMP_UP or RAMP_DOWN, else 0.
REQ-022 Latency: a led_in change sampled at edge t SHALL change the state at edge t+1.
REQ-023 Step timing: the first level change SHALL follow STEP_DIV cycles later.

Reset
REQ-024 While rst=1: state=OFF, level=0, prescaler=0, pwm_cnt=0, led_out=0, busy=0.
REQ-025 rst=1 SHALL override led_in and any ramp in progress.
REQ-026 After rst returns to 0, normal operation SHALL start from OFF on the next edge.

Configuration
REQ-027 Macro LED_FADE_GAMMA_EN defined: duty_eff = (level*level) >> PWM_BITS.
REQ-028 The LED_FADE_GAMMA_EN product SHALL be computed at 2*PWM_BITS width, with no truncation before the shift.
REQ-029 Macro LED_FADE_GAMMA_EN undefined: duty_eff = level; no multiplier is instantiated.
REQ-030 duty SHALL report the linear level in both builds.

Structure
REQ-031 Shared package led_pkg SHALL hold the 2-bit state encodings (OFF=0, RAMP_UP=1, ON=2, RAMP_DOWN=3) and default PWM_BITS/STEP_DIV constants.
REQ-032 Sub-module led_pwm_gen SHALL hold the PWM counter, compare and led_out register.
REQ-033 FSM, prescaler and gamma logic SHALL stay in led_fade_driver.

Verification (PWM_BITS=4, STEP_DIV=2, MAX=15 unless noted)
REQ-034 Reset check: rst=1 for 3 cycles with led_in=1 -> led_out=0, duty=0, busy=0 throughout; RAMP_UP is entered one edge after rst drops.
REQ-035 Full ramp up: hold led_in=1 -> busy=1; duty steps +1 every 2 cycles; reaches 15 and ON after 30 cycles; then busy=0 and led_out constant 1.
REQ-036 Reversal during ramp up: drop led_in when duty=6 -> state=RAMP_DOWN next edge, duty stays 6; duty=5 two cycles later; reaches 0 and OFF 12 cycles after reversal, led_out=0.
REQ-037 Duty-cycle check: STEP_DIV=1000, sample during a ramp at level 8 -> led_out high exactly 8 of every 16 cycles; at level 3 -> high 3 of 16.
REQ-038 Reset mid-ramp: assert rst at duty=9 with led_in=1 -> next edge duty=0, led_out=0, OFF; after release, duty climbs again from 0.
REQ-039 Gamma build: LED_FADE_GAMMA_EN defined, level 8 -> high 4 of 16 cycles while duty reads 8; macro undefined -> high 8 of 16.
